// File: rtl/dma_mc_if.sv
// Register-write, DRAM and device bus bundle for the multi-channel DMA engine.
// The master modport is the engine's view of the bundle; the slave modport is the register/memory/device side.
interface dma_mc_if #(
  parameter int NCH = 2,
  parameter int AW  = 21
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           reg_we;
  logic [CHW-1:0] reg_ch;
  logic [3:0]     reg_sel;
  logic [7:0]     reg_data;

  logic           dram_req;
  logic           dram_rnw;
  logic [AW-1:0]  dram_addr;
  logic [15:0]    dram_wrdata;
  logic [15:0]    dram_rddata;
  logic           dram_next;

  logic           dev_req;
  logic           dev_rnw;
  logic [CHW-1:0] dev_ch;
  logic [15:0]    dev_wrdata;
  logic [15:0]    dev_rddata;
  logic           dev_stb;

  logic [NCH-1:0] ch_act;
  logic [NCH-1:0] int_done;

  modport master (
    input  reg_we, reg_ch, reg_sel, reg_data, dram_rddata, dram_next, dev_rddata, dev_stb,
    output dram_req, dram_rnw, dram_addr, dram_wrdata,
    output dev_req, dev_rnw, dev_ch, dev_wrdata, ch_act, int_done
  );

  modport slave (
    output reg_we, reg_ch, reg_sel, reg_data, dram_rddata, dram_next, dev_rddata, dev_stb,
    input  dram_req, dram_rnw, dram_addr, dram_wrdata,
    input  dev_req, dev_rnw, dev_ch, dev_wrdata, ch_act, int_done
  );
endinterface

// File: rtl/dma_mc.sv
// Multi-channel DMA: one shared word-at-a-time engine, round-robin per burst, modes dev->RAM, RAM->dev, copy, fill.
// Define DMA_MC_ALIGN_EN to enable aligned addressing selected by ctrl[2] (src) and ctrl[3] (dst).
module dma_mc #(
  parameter int NCH = 2,
  parameter int AW  = 21,
  parameter int LW  = 8
) (
  input  logic      clk,
  input  logic      reset,
  dma_mc_if.master  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARB  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] STEP = 3'd4;

  logic [AW-1:0]  src_r   [NCH];
  logic [AW-1:0]  dst_r   [NCH];
  logic [AW-1:0]  cur_src [NCH];
  logic [AW-1:0]  cur_dst [NCH];
  logic [LW-1:0]  len_r   [NCH];
  logic [LW-1:0]  num_r   [NCH];
  logic [LW-1:0]  wcnt    [NCH];
  logic [LW-1:0]  bcnt    [NCH];
  logic [15:0]    fill_r  [NCH];
  logic [1:0]     mode_r  [NCH];
  logic [NCH-1:0] al_src, al_dst;

  logic [NCH-1:0] act, done;
  logic [2:0]     state;
  logic [CHW-1:0] gnt, rr_ptr, pick;
  logic           pick_vld;
  logic [15:0]    rdata;

  logic           ctrl_wr, abort, burst_end, last_word, rd_ack, wr_ack;
  logic [1:0]     mode_g;

  function automatic logic [AW-1:0] set_byte(input logic [AW-1:0] old, input logic [1:0] idx,
                                             input logic [7:0] d);
    logic [23:0] t;
    t = 24'(old);
    case (idx)
      2'd0:    t[7:0]   = d;
      2'd1:    t[15:8]  = d;
      default: t[23:16] = d;
    endcase
    return t[AW-1:0];
  endfunction

  // Aligned mode keeps the launch low byte and steps the upper field at each burst end.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur, input logic [7:0] base_lo,
                                              input logic align, input logic bend);
    if (align && bend)
      return {cur[AW-1:8] + (AW-8)'(1), base_lo};
    return cur + AW'(1);
  endfunction

  assign ctrl_wr   = bus.reg_we && (bus.reg_sel == 4'd10);
  assign mode_g    = mode_r[gnt];
  assign burst_end = (wcnt[gnt] == '0);
  assign last_word = burst_end && (bcnt[gnt] == '0);
  assign rd_ack    = (mode_g == 2'd0) ? bus.dev_stb : bus.dram_next;
  assign wr_ack    = (mode_g == 2'd1) ? bus.dev_stb : bus.dram_next;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!pick_vld && act[(int'(rr_ptr) + i) % NCH]) begin
        pick     = CHW'((int'(rr_ptr) + i) % NCH);
        pick_vld = 1'b1;
      end
    end
  end

  // A ctrl write to the channel holding (or about to take) the engine restarts it from IDLE.
  assign abort = ctrl_wr &&
                 ((((state == RD) || (state == WR) || (state == STEP)) && (bus.reg_ch == gnt)) ||
                  ((state == ARB) && pick_vld && (bus.reg_ch == pick)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      act    <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      for (int c = 0; c < NCH; c++)
        if (ctrl_wr && (bus.reg_ch == CHW'(c))) act[c] <= 1'b1;
      case (state)
        IDLE: if (|act) state <= ARB;
        ARB: begin
          if (!pick_vld) begin
            state <= IDLE;
          end else begin
            gnt    <= pick;
            rr_ptr <= (pick == CHW'(NCH-1)) ? '0 : pick + CHW'(1);
            state  <= (mode_r[pick] == 2'd3) ? WR : RD;
          end
        end
        RD: if (rd_ack) state <= WR;
        WR: if (wr_ack) state <= STEP;
        STEP: begin
          if (last_word) begin
            act[gnt]  <= 1'b0;
            done[gnt] <= 1'b1;
            state     <= IDLE;
          end else if (burst_end) begin
            state <= ARB;
          end else begin
            state <= (mode_g == 2'd3) ? WR : RD;
          end
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        state             <= IDLE;
        act[bus.reg_ch]   <= 1'b1;
        done[bus.reg_ch]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == RD) && rd_ack)
      rdata <= (mode_g == 2'd0) ? bus.dev_rddata : bus.dram_rddata;
    for (int c = 0; c < NCH; c++) begin
      if (bus.reg_we && (bus.reg_ch == CHW'(c))) begin
        if (bus.reg_sel == 4'd10) begin
          mode_r[c]  <= bus.reg_data[1:0];
          wcnt[c]    <= len_r[c];
          bcnt[c]    <= num_r[c];
          cur_src[c] <= src_r[c];
          cur_dst[c] <= dst_r[c];
`ifdef DMA_MC_ALIGN_EN
          al_src[c]  <= bus.reg_data[2];
          al_dst[c]  <= bus.reg_data[3];
`endif
        end else if (!act[c]) begin
          case (bus.reg_sel)
            4'd0:    src_r[c]        <= set_byte(src_r[c], 2'd0, bus.reg_data);
            4'd1:    src_r[c]        <= set_byte(src_r[c], 2'd1, bus.reg_data);
            4'd2:    src_r[c]        <= set_byte(src_r[c], 2'd2, bus.reg_data);
            4'd3:    dst_r[c]        <= set_byte(dst_r[c], 2'd0, bus.reg_data);
            4'd4:    dst_r[c]        <= set_byte(dst_r[c], 2'd1, bus.reg_data);
            4'd5:    dst_r[c]        <= set_byte(dst_r[c], 2'd2, bus.reg_data);
            4'd6:    len_r[c]        <= bus.reg_data[LW-1:0];
            4'd7:    num_r[c]        <= bus.reg_data[LW-1:0];
            4'd8:    fill_r[c][7:0]  <= bus.reg_data;
            4'd9:    fill_r[c][15:8] <= bus.reg_data;
            default: ;
          endcase
        end
      end else if ((state == STEP) && (gnt == CHW'(c))) begin
        wcnt[c] <= burst_end ? len_r[c] : wcnt[c] - LW'(1);
        if (burst_end) bcnt[c] <= bcnt[c] - LW'(1);
        if ((mode_r[c] == 2'd1) || (mode_r[c] == 2'd2))
          cur_src[c] <= next_addr(cur_src[c], src_r[c][7:0], al_src[c], burst_end);
        if (mode_r[c] != 2'd1)
          cur_dst[c] <= next_addr(cur_dst[c], dst_r[c][7:0], al_dst[c], burst_end);
      end
    end
  end

`ifndef DMA_MC_ALIGN_EN
  assign al_src = '0;
  assign al_dst = '0;
`endif

  // Bus outputs decode from engine state and stay fixed while a word is pending.
  assign bus.dram_req    = ((state == RD) && (mode_g != 2'd0)) || ((state == WR) && (mode_g != 2'd1));
  assign bus.dev_req     = ((state == RD) && (mode_g == 2'd0)) || ((state == WR) && (mode_g == 2'd1));
  assign bus.dram_rnw    = (state != WR);
  assign bus.dev_rnw     = (state != WR);
  assign bus.dram_addr   = (state == RD) ? cur_src[gnt] : cur_dst[gnt];
  assign bus.dram_wrdata = (mode_g == 2'd3) ? fill_r[gnt] : rdata;
  assign bus.dev_wrdata  = rdata;
  assign bus.dev_ch      = gnt;
  assign bus.ch_act      = act;
  assign bus.int_done    = done;
endmodule

// File: tb/tb_dma_mc.sv
// Scoreboard bench for dma_mc: bench-side DRAM/device responders log every accepted word against expected transactions.
module tb_dma_mc;
  localparam int NCH = 2;
  localparam int AW  = 21;
  localparam int LW  = 8;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_mc_if #(.NCH(NCH), .AW(AW)) bus ();
  dma_mc #(.NCH(NCH), .AW(AW), .LW(LW)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];
  logic [15:0] mem [int];
  int dram_lat = 1, dev_lat = 1;
  int dcnt = 0, vcnt = 0, dev_rd_n = 0, dram_wr_n = 0, dev_rd_cyc = 0, stab_err = 0;
  int done_cnt [NCH] = '{default: 0};
  int rsp_a;
  logic [15:0] rsp_d;
  logic prev_dram_req = 1'b0, prev_dram_next = 1'b0, prev_dev_req = 1'b0, prev_dev_stb = 1'b0;
  logic [AW+16:0] prev_dram_vec;
  logic [CHW+16:0] prev_dev_vec;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // kind: 1 dram read, 2 dram write, 3 device read, 4 device write
  function automatic logic [63:0] txn(input int kind, input int ch, input int addr, input logic [15:0] data);
    return {16'h0, 4'(kind), 4'(ch), 24'(addr), data};
  endfunction

  task automatic sb_check(input logic [63:0] obs);
    if (exp_q.size() == 0) check_eq("sb_unexpected", obs, 64'h0);
    else check_eq("sb_txn", obs, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bus.dram_next = 1'b0;
      bus.dev_stb = 1'b0;
      bus.dram_rddata = 16'h0;
      bus.dev_rddata = 16'h0;
      dcnt = 0;
      vcnt = 0;
      prev_dram_req = 1'b0;
      prev_dev_req = 1'b0;
    end else begin
      if (bus.dram_req && bus.dev_req) stab_err++;
      if (prev_dram_req && !prev_dram_next && bus.dram_req &&
          ({bus.dram_rnw, bus.dram_addr, bus.dram_wrdata} !== prev_dram_vec)) stab_err++;
      if (prev_dev_req && !prev_dev_stb && bus.dev_req &&
          ({bus.dev_rnw, bus.dev_ch, bus.dev_wrdata} !== prev_dev_vec)) stab_err++;
      if (bus.dev_req && bus.dev_rnw) dev_rd_cyc++;
      for (int c = 0; c < NCH; c++) if (bus.int_done[c]) done_cnt[c]++;

      if (bus.dram_next) begin
        bus.dram_next = 1'b0;
        dcnt = 0;
      end else if (bus.dram_req) begin
        dcnt++;
        if (dcnt >= dram_lat) begin
          bus.dram_next = 1'b1;
          rsp_a = int'(bus.dram_addr);
          if (bus.dram_rnw) begin
            rsp_d = mem.exists(rsp_a) ? mem[rsp_a] : 16'h0;
            bus.dram_rddata = rsp_d;
            sb_check(txn(1, int'(bus.dev_ch), rsp_a, rsp_d));
          end else begin
            mem[rsp_a] = bus.dram_wrdata;
            dram_wr_n++;
            sb_check(txn(2, int'(bus.dev_ch), rsp_a, bus.dram_wrdata));
          end
        end
      end

      if (bus.dev_stb) begin
        bus.dev_stb = 1'b0;
        vcnt = 0;
      end else if (bus.dev_req) begin
        vcnt++;
        if (vcnt >= dev_lat) begin
          bus.dev_stb = 1'b1;
          if (bus.dev_rnw) begin
            rsp_d = 16'hA000 + 16'(dev_rd_n);
            dev_rd_n++;
            bus.dev_rddata = rsp_d;
            sb_check(txn(3, int'(bus.dev_ch), 0, rsp_d));
          end else begin
            sb_check(txn(4, int'(bus.dev_ch), 0, bus.dev_wrdata));
          end
        end
      end

      prev_dram_req  = bus.dram_req;
      prev_dram_next = bus.dram_next;
      prev_dram_vec  = {bus.dram_rnw, bus.dram_addr, bus.dram_wrdata};
      prev_dev_req   = bus.dev_req;
      prev_dev_stb   = bus.dev_stb;
      prev_dev_vec   = {bus.dev_rnw, bus.dev_ch, bus.dev_wrdata};
    end
  end

  task automatic wr_reg(input int ch, input int sel, input int data);
    bus.reg_we   = 1'b1;
    bus.reg_ch   = CHW'(ch);
    bus.reg_sel  = 4'(sel);
    bus.reg_data = 8'(data);
    @(negedge clk);
    bus.reg_we   = 1'b0;
  endtask

  task automatic set_addr(input int ch, input int base, input int addr);
    wr_reg(ch, base,     addr & 255);
    wr_reg(ch, base + 1, (addr >> 8) & 255);
    wr_reg(ch, base + 2, (addr >> 16) & 255);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[ch] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_cnt", done_cnt[ch], target);
    check_eq("act_clear", bus.ch_act[ch], 0);
  endtask

  initial begin
    int b0, b1, w0, n, st0, cyc0;
    logic [15:0] d;
    bus.reg_we = 1'b0;
    bus.reg_ch = '0;
    bus.reg_sel = '0;
    bus.reg_data = '0;
    @(negedge clk);
    check_eq("rst_ch_act", bus.ch_act, 0);
    check_eq("rst_int_done", bus.int_done, 0);
    check_eq("rst_dram_req", bus.dram_req, 0);
    check_eq("rst_dev_req", bus.dev_req, 0);
    check_eq("rst_dram_rnw", bus.dram_rnw, 1);
    check_eq("rst_dev_rnw", bus.dev_rnw, 1);
    @(negedge clk);
    reset = 1'b0;

    // RAM->RAM copy of four words, reads and writes interleaved
    for (int i = 0; i < 4; i++) mem['h100 + i] = 16'h5A00 + 16'(i);
    set_addr(0, 0, 'h100);
    set_addr(0, 3, 'h200);
    wr_reg(0, 6, 3);
    wr_reg(0, 7, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(txn(1, 0, 'h100 + i, 16'h5A00 + 16'(i)));
      exp_q.push_back(txn(2, 0, 'h200 + i, 16'h5A00 + 16'(i)));
    end
    b0 = done_cnt[0];
    wr_reg(0, 10, 2);
    wait_done(0, b0 + 1, 200);
    for (int i = 0; i < 4; i++) check_eq("copy_data", mem['h200 + i], 16'h5A00 + 16'(i));
    check_eq("sb_left_copy", exp_q.size(), 0);

    // two fill channels alternate bursts
    do_reset();
    set_addr(0, 3, 'h1000);
    wr_reg(0, 8, 'h34); wr_reg(0, 9, 'h12); wr_reg(0, 6, 1); wr_reg(0, 7, 2);
    set_addr(1, 3, 'h2000);
    wr_reg(1, 8, 'hEF); wr_reg(1, 9, 'hBE); wr_reg(1, 6, 1); wr_reg(1, 7, 2);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 2; c++)
        for (int w = 0; w < 2; w++)
          exp_q.push_back(txn(2, c, (c == 0 ? 'h1000 : 'h2000) + b * 2 + w, (c == 0) ? 16'h1234 : 16'hBEEF));
    b0 = done_cnt[0];
    b1 = done_cnt[1];
    wr_reg(0, 10, 3);
    wr_reg(1, 10, 3);
    wait_done(0, b0 + 1, 400);
    wait_done(1, b1 + 1, 400);
    check_eq("sb_left_rr", exp_q.size(), 0);

    // device->RAM with a slow device strobe
    do_reset();
    dev_lat = 5;
    set_addr(0, 3, 'h300);
    wr_reg(0, 6, 0);
    wr_reg(0, 7, 0);
    d = 16'hA000 + 16'(dev_rd_n);
    exp_q.push_back(txn(3, 0, 0, d));
    exp_q.push_back(txn(2, 0, 'h300, d));
    cyc0 = dev_rd_cyc;
    st0 = stab_err;
    b0 = done_cnt[0];
    wr_reg(0, 10, 0);
    wait_done(0, b0 + 1, 200);
    check_eq("dev_req_hold", dev_rd_cyc - cyc0, 5);
    check_eq("stable_outputs", stab_err - st0, 0);
    check_eq("dev_word", mem['h300], d);
    check_eq("sb_left_dev", exp_q.size(), 0);
    dev_lat = 1;

    // destination wraps at the top of the address space
    do_reset();
    set_addr(1, 3, 'h1FFFFF);
    wr_reg(1, 8, 'hFF); wr_reg(1, 9, 'h00); wr_reg(1, 6, 1); wr_reg(1, 7, 0);
    exp_q.push_back(txn(2, 1, 'h1FFFFF, 16'h00FF));
    exp_q.push_back(txn(2, 1, 'h000000, 16'h00FF));
    b1 = done_cnt[1];
    wr_reg(1, 10, 3);
    wait_done(1, b1 + 1, 200);
    check_eq("sb_left_wrap", exp_q.size(), 0);

    // reset in the middle of a burst, then relaunch from the retained registers
    do_reset();
    for (int i = 0; i < 8; i++) mem['h100 + i] = 16'h7700 + 16'(i);
    set_addr(0, 0, 'h100);
    set_addr(0, 3, 'h400);
    wr_reg(0, 6, 7);
    wr_reg(0, 7, 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(txn(1, 0, 'h100 + i, 16'h7700 + 16'(i)));
      exp_q.push_back(txn(2, 0, 'h400 + i, 16'h7700 + 16'(i)));
    end
    w0 = dram_wr_n;
    b0 = done_cnt[0];
    wr_reg(0, 10, 2);
    n = 0;
    while (dram_wr_n < w0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_burst_reached", dram_wr_n - w0, 3);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_ch_act", bus.ch_act, 0);
    check_eq("rst_mid_dram_req", bus.dram_req, 0);
    check_eq("rst_mid_dev_req", bus.dev_req, 0);
    check_eq("rst_mid_int_done", bus.int_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("no_done_on_reset", done_cnt[0], b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(txn(1, 0, 'h100 + i, 16'h7700 + 16'(i)));
      exp_q.push_back(txn(2, 0, 'h400 + i, 16'h7700 + 16'(i)));
    end
    wr_reg(0, 10, 2);
    wait_done(0, b0 + 1, 400);
    check_eq("relaunch_last_word", mem['h407], 16'h7707);
    check_eq("sb_left_relaunch", exp_q.size(), 0);

`ifdef DMA_MC_ALIGN_EN
    // aligned destination: low byte reloads, upper field steps at burst end
    do_reset();
    set_addr(0, 3, 'h310);
    wr_reg(0, 8, 'h0A); wr_reg(0, 9, 'h0A); wr_reg(0, 6, 1); wr_reg(0, 7, 1);
    exp_q.push_back(txn(2, 0, 'h310, 16'h0A0A));
    exp_q.push_back(txn(2, 0, 'h311, 16'h0A0A));
    exp_q.push_back(txn(2, 0, 'h410, 16'h0A0A));
    exp_q.push_back(txn(2, 0, 'h411, 16'h0A0A));
    b0 = done_cnt[0];
    wr_reg(0, 10, 'h0B);
    wait_done(0, b0 + 1, 200);
    check_eq("sb_left_align", exp_q.size(), 0);
`endif

    check_eq("outputs_stable_all", stab_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
